apbuart: RTL and testbench
==========================

// Module: apbuart
// PURPOSE
//  APB3 slave UART, 8N1 only, with 16-entry TX and RX FIFOs, a 16-bit baud prescaler and one maskable level interrupt.
//  Serves as a peripheral on the SoC APB bus. Baud = PCLK/((PR+1)*16), with 16x oversampling.
// PARAMETERS
//  FIFO_AW  4  log2 of FIFO depth (depth 16); level counters are FIFO_AW+1 bits wide
// PORTS
//  PCLK      in   1   sole clock
//  PRESET    in   1   asynchronous reset, active-high
//  PSEL      in   1   APB select
//  PENABLE   in   1   APB access phase
//  PWRITE    in   1   1 = write
//  PADDR     in   32  byte address; only [7:0] decoded
//  PWDATA    in   32  write data
//  PREADY    out  1   tied to 1 (no wait states)
//  PRDATA    out  32  read data, combinational from PADDR[7:0]
//  RsRx      in   1   serial input (idle high)
//  RsTx      out  1   serial output (idle high)
//  uart_irq  out  1   interrupt, level, combinational
// BEHAVIOUR
//  Access strobe: acc = PSEL & PENABLE. All writes occur on the acc & PWRITE edge.
//  Register map:
//   00 DATA: W pushes PWDATA[7:0] to TX FIFO, dropped if full. R returns {24'b0, RX head}; acc & ~PWRITE pops RX (no-op if empty).
//   04 R STATUS {26'b0, rx_gt_thr, tx_lt_thr, rx_empty, rx_full, tx_empty, tx_full}.
//   04 W CTRL[0] EN. CTRL is not readable.
//   08 PRESCALE[15:0] RW.  0C IM[4:0] RW.  10 TXFIFOTR[7:0] RW.  14 RXFIFOTR[7:0] RW.
//   Any other offset reads 32'hDEADDEAD; writes to it are ignored.
//  Reset values: all registers 0; FIFOs empty; RsTx=1; uart_irq=0; both FSMs in IDLE.
//  tx_lt_thr = tx_level < TXFIFOTR; rx_gt_thr = rx_level > RXFIFOTR. Both compares are unsigned.
//  uart_irq = IM[0] & ((~tx_full&IM[1]) | (~rx_empty&IM[2]) | (tx_lt_thr&IM[3]) | (rx_gt_thr&IM[4])).
//  Baud generator:
//   - 16-bit counter advances only while EN; wraps at PRESCALE.
//   - tick = (cnt==PRESCALE). EN=0 freezes cnt and all FSM tick progress.
//  FIFO:
//   - Push on full is ignored; pop on empty is ignored.
//   - Simultaneous push+pop when not empty and not full: level unchanged, both pointers advance.
//   - Simultaneous push+pop when empty: push only. When full: pop only.
//   - Pointers wrap mod 16. level ranges 0..16.
//  TX FSM (IDLE, START, DATA, STOP):
//   - IDLE drives 1 and leaves on !tx_empty, latching the head byte.
//   - START drives 0, DATA drives LSB first, STOP drives 1; each bit lasts 16 ticks.
//   - End of STOP pops the TX FIFO (1-cycle strobe) and returns to IDLE.
//  RX FSM (IDLE, START, DATA, STOP):
//   - IDLE leaves on RsRx=0.
//   - START waits 8 ticks (mid-bit); if RsRx=1 at that point, return to IDLE (glitch reject).
//   - DATA samples every 16 ticks, shifting LSB first, 8 bits.
//   - STOP waits 16 ticks, then pushes the byte (dropped if RX full) and returns to IDLE. No framing check.
//  Reset mid-frame aborts immediately to IDLE with RsTx=1.
// CONFIGURATION
//  APBUART_FIFO_THRESH_EN defined: TXFIFOTR/RXFIFOTR registers, status bits 4/5 and IM[3]/IM[4] as above.
//  Undefined: 10/14 read 0 and writes are ignored; tx_lt_thr = rx_gt_thr = 0; IM[3]/IM[4] stored but have no effect.
// STRUCTURE
//  Package apbuart_pkg: register offset constants, FSM state enum, DEADDEAD default value.
//  Sub-module apbuart_fifo (parameter FIFO_AW, 8-bit data), instantiated twice.
//  Baud generator and TX/RX FSMs stay inline.
// TESTING
//  Benches tie RsRx=RsTx (loopback). Expected values assume APBUART_FIFO_THRESH_EN defined.
//  1) Reset, then read 08/0C/10/14 -> 0. Read 04 -> 0x0A. Read 18 -> 0xDEADDEAD. PREADY=1 always.
//  2) PR=1, EN=1, write 0x7F to 00 -> RsTx low for 32 clk, bits 1111_1110 LSB first, 320 clk per frame.
//     After the frame, 04 reads 0x22 and a read of 00 returns 0x7F; 04 then reads 0x0A.
//  3) 17 writes to 00 with EN=0 -> tx_full=1 and 04 bit0=1.
//     Set EN=1 -> exactly 16 bytes are looped back; RX holds 16 and 04 bit2=1.
//  4) IM=0x05 with RX empty -> irq=0; after one byte is received irq=1; read 00 -> irq=0.
//     IM=0x03 with TX not full -> irq=1.
//  5) TXFIFOTR=6, IM=0x09, EN=0, write 3 bytes -> irq=1 (3<6).
//     RXFIFOTR=1, IM=0x11: 2 bytes received -> irq=1; after one pop -> irq=0.
//  6) Assert PRESET mid-frame -> RsTx=1 next cycle, FIFOs empty, 04 reads 0x0A.
//     Separately, a 3-tick low pulse on RsRx -> no byte pushed.

Source files
------------

// File: rtl/apbuart_pkg.sv
// ============================================================================
//  Module   : apbuart_pkg
//  Purpose  : Shared constants and types for the APB UART: register byte
//             offsets, the default read value for unmapped offsets, and the
//             serial FSM state enum used by both the TX and RX engines.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package apbuart_pkg;

    // Register byte offsets (PADDR[7:0])
    localparam logic [7:0] c_OFF_DATA  = 8'h00;
    localparam logic [7:0] c_OFF_STAT  = 8'h04;  // R: STATUS, W: CTRL
    localparam logic [7:0] c_OFF_PRESC = 8'h08;
    localparam logic [7:0] c_OFF_IM    = 8'h0C;
    localparam logic [7:0] c_OFF_TXTR  = 8'h10;
    localparam logic [7:0] c_OFF_RXTR  = 8'h14;

    // Returned for any offset outside the register map
    localparam logic [31:0] c_DEFAULT_RD = 32'hDEAD_DEAD;

    // Serial frame engine states (shared by TX and RX)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage : apbuart_pkg

`default_nettype wire

// File: rtl/apbuart_if.sv
// ============================================================================
//  Module   : apbuart_if
//  Purpose  : APB3 bus bundle for the UART peripheral.
//  Signals  : PSEL, PENABLE, PWRITE, PADDR[31:0], PWDATA[31:0] (master->slave)
//             PREADY, PRDATA[31:0]                           (slave->master)
//  Modports : master (bus driver / testbench), slave (apbuart)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apbuart_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PREADY, PRDATA
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PREADY, PRDATA
    );
endinterface : apbuart_if

`default_nettype wire

// File: rtl/apbuart_fifo.sv
// ============================================================================
//  Module   : apbuart_fifo
//  Purpose  : Synchronous byte FIFO of depth 2**FIFO_AW with a level count.
//             Push when full and pop when empty are ignored; a simultaneous
//             push+pop moves both pointers and leaves the level unchanged.
//  Ports    : clk, rst (async, active-high)
//             push_i, din_i[7:0]   - write side
//             pop_i,  dout_o[7:0]  - read side (dout_o = current head)
//             full_o, empty_o, level_o[FIFO_AW:0]
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apbuart_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [7:0]         din_i,
    input  logic               pop_i,
    output logic [7:0]         dout_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [FIFO_AW:0]   level_o
);

    localparam int               c_DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] c_FULL_LVL = (FIFO_AW + 1)'(c_DEPTH);

    logic [7:0]         mem_q [c_DEPTH];
    logic [FIFO_AW-1:0] wptr_q, wptr_d;
    logic [FIFO_AW-1:0] rptr_q, rptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               w_do_push;
    logic               w_do_pop;

    assign full_o  = (level_q == c_FULL_LVL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign dout_o  = mem_q[rptr_q];

    // Gating by full/empty also yields "pop only when full" and
    // "push only when empty" for simultaneous requests.
    assign w_do_push = push_i & ~full_o;
    assign w_do_pop  = pop_i  & ~empty_o;

    always_comb begin
        wptr_d  = wptr_q + FIFO_AW'(w_do_push);
        rptr_d  = rptr_q + FIFO_AW'(w_do_pop);
        level_d = level_q + (FIFO_AW + 1)'(w_do_push) - (FIFO_AW + 1)'(w_do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: contents are only visible below level_q.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wptr_q] <= din_i;
        end
    end

endmodule : apbuart_fifo

`default_nettype wire

// File: rtl/apbuart.sv
// ============================================================================
//  Module   : apbuart
//  Purpose  : APB3 slave UART, 8N1, 16x oversampling, TX/RX FIFOs, 16-bit
//             baud prescaler (baud = PCLK/((PR+1)*16)), one level interrupt.
//  Ports    : PCLK, PRESET (async, active-high)
//             apb       - apbuart_if.slave (PSEL/PENABLE/PWRITE/PADDR/PWDATA,
//                         PREADY tied 1, PRDATA combinational)
//             RsRx      - serial in (idle high), RsTx - serial out (idle high)
//             uart_irq  - combinational level interrupt
//  Config   : APBUART_FIFO_THRESH_EN enables TXFIFOTR/RXFIFOTR (0x10/0x14),
//             STATUS bits 4/5 and interrupt sources IM[3]/IM[4].
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apbuart
    import apbuart_pkg::*;
#(
    parameter int FIFO_AW = 4
) (
    input  logic       PCLK,
    input  logic       PRESET,
    apbuart_if.slave   apb,
    input  logic       RsRx,
    output logic       RsTx,
    output logic       uart_irq
);

    // ---------------------------------------------------------------- APB
    logic       w_acc, w_wr, w_rd;
    logic [7:0] w_off;

    assign w_acc = apb.PSEL & apb.PENABLE;
    assign w_wr  = w_acc & apb.PWRITE;
    assign w_rd  = w_acc & ~apb.PWRITE;
    assign w_off = apb.PADDR[7:0];

    logic        en_q;
    logic [15:0] prescale_q;
    logic [4:0]  im_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            en_q       <= 1'b0;
            prescale_q <= '0;
            im_q       <= '0;
        end else if (w_wr) begin
            case (w_off)
                c_OFF_STAT:  en_q       <= apb.PWDATA[0];
                c_OFF_PRESC: prescale_q <= apb.PWDATA[15:0];
                c_OFF_IM:    im_q       <= apb.PWDATA[4:0];
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------- FIFOs
    logic             tx_push, tx_pop, tx_full, tx_empty;
    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]       tx_dout, rx_dout, rx_din;
    logic [FIFO_AW:0] tx_level, rx_level;

    assign tx_push = w_wr & (w_off == c_OFF_DATA);
    assign rx_pop  = w_rd & (w_off == c_OFF_DATA);

    apbuart_fifo #(.FIFO_AW(FIFO_AW)) u_tx_fifo (
        .clk     (PCLK),
        .rst     (PRESET),
        .push_i  (tx_push),
        .din_i   (apb.PWDATA[7:0]),
        .pop_i   (tx_pop),
        .dout_o  (tx_dout),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .level_o (tx_level)
    );

    apbuart_fifo #(.FIFO_AW(FIFO_AW)) u_rx_fifo (
        .clk     (PCLK),
        .rst     (PRESET),
        .push_i  (rx_push),
        .din_i   (rx_din),
        .pop_i   (rx_pop),
        .dout_o  (rx_dout),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .level_o (rx_level)
    );

    // --------------------------------------------------------- thresholds
    logic        w_tx_lt_thr, w_rx_gt_thr;
    logic [31:0] w_rd_txtr, w_rd_rxtr;

`ifdef APBUART_FIFO_THRESH_EN
    logic [7:0] txtr_q, rxtr_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            txtr_q <= '0;
            rxtr_q <= '0;
        end else if (w_wr) begin
            if (w_off == c_OFF_TXTR) txtr_q <= apb.PWDATA[7:0];
            if (w_off == c_OFF_RXTR) rxtr_q <= apb.PWDATA[7:0];
        end
    end

    assign w_tx_lt_thr = (32'(tx_level) < 32'(txtr_q));
    assign w_rx_gt_thr = (32'(rx_level) > 32'(rxtr_q));
    assign w_rd_txtr   = {24'b0, txtr_q};
    assign w_rd_rxtr   = {24'b0, rxtr_q};
`else
    logic w_unused_thr;
    assign w_tx_lt_thr  = 1'b0;
    assign w_rx_gt_thr  = 1'b0;
    assign w_rd_txtr    = '0;
    assign w_rd_rxtr    = '0;
    assign w_unused_thr = ^{tx_level, rx_level};
`endif

    // ---------------------------------------------------------- read mux
    always_comb begin
        apb.PRDATA = c_DEFAULT_RD;
        case (w_off)
            c_OFF_DATA:  apb.PRDATA = {24'b0, rx_dout};
            c_OFF_STAT:  apb.PRDATA = {26'b0, w_rx_gt_thr, w_tx_lt_thr,
                                       rx_empty, rx_full, tx_empty, tx_full};
            c_OFF_PRESC: apb.PRDATA = {16'b0, prescale_q};
            c_OFF_IM:    apb.PRDATA = {27'b0, im_q};
            c_OFF_TXTR:  apb.PRDATA = w_rd_txtr;
            c_OFF_RXTR:  apb.PRDATA = w_rd_rxtr;
            default:     apb.PRDATA = c_DEFAULT_RD;
        endcase
    end

    assign apb.PREADY = 1'b1;

    assign uart_irq = im_q[0] & ((~tx_full    & im_q[1]) |
                                 (~rx_empty   & im_q[2]) |
                                 (w_tx_lt_thr & im_q[3]) |
                                 (w_rx_gt_thr & im_q[4]));

    logic w_unused;
    assign w_unused = ^{apb.PADDR[31:8], apb.PWDATA[31:16]};

    // ------------------------------------------------------ baud generator
    logic [15:0] cnt_q;
    logic        w_tick;

    assign w_tick = en_q & (cnt_q == prescale_q);

    // Wrapping on >= keeps the counter from running through 65535 when
    // PRESCALE is lowered below the frozen count.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt_q <= '0;
        end else if (en_q) begin
            cnt_q <= (cnt_q >= prescale_q) ? 16'd0 : cnt_q + 16'd1;
        end
    end

    // -------------------------------------------------------------- TX FSM
    uart_state_e tx_state_q, tx_state_d;
    logic [3:0]  tx_tcnt_q, tx_tcnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tx_state_q <= ST_IDLE;
            tx_tcnt_q  <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_pop     = 1'b0;
        // Tick counter wraps naturally at 16; bit boundary at count 15.
        if (tx_state_q != ST_IDLE && w_tick) begin
            tx_tcnt_d = tx_tcnt_q + 4'd1;
        end
        case (tx_state_q)
            ST_IDLE: begin
                if (!tx_empty) begin
                    tx_state_d = ST_START;
                    tx_sh_d    = tx_dout;
                    tx_tcnt_d  = '0;
                    tx_bit_d   = '0;
                end
            end
            ST_START: begin
                if (w_tick && tx_tcnt_q == 4'hF) tx_state_d = ST_DATA;
            end
            ST_DATA: begin
                if (w_tick && tx_tcnt_q == 4'hF) begin
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // The head byte stays in the FIFO until its frame completes.
                if (w_tick && tx_tcnt_q == 4'hF) begin
                    tx_state_d = ST_IDLE;
                    tx_pop     = 1'b1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    assign RsTx = (tx_state_q == ST_START) ? 1'b0 :
                  (tx_state_q == ST_DATA)  ? tx_sh_q[0] : 1'b1;

    // -------------------------------------------------------------- RX FSM
    // Two-flop synchronizer for the asynchronous serial input.
    logic rx_meta_q, rx_sync_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= RsRx;
            rx_sync_q <= rx_meta_q;
        end
    end

    uart_state_e rx_state_q, rx_state_d;
    logic [3:0]  rx_tcnt_q, rx_tcnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;

    assign rx_din = rx_sh_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_state_q <= ST_IDLE;
            rx_tcnt_q  <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_push    = 1'b0;
        if (rx_state_q != ST_IDLE && w_tick) begin
            rx_tcnt_d = rx_tcnt_q + 4'd1;
        end
        case (rx_state_q)
            ST_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = ST_START;
                    rx_tcnt_d  = '0;
                    rx_bit_d   = '0;
                end
            end
            ST_START: begin
                // Mid start bit: a high line here was a glitch.
                if (w_tick && rx_tcnt_q == 4'd7) begin
                    rx_tcnt_d  = '0;
                    rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick && rx_tcnt_q == 4'hF) begin
                    rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tick && rx_tcnt_q == 4'hF) begin
                    rx_state_d = ST_IDLE;
                    rx_push    = 1'b1;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

endmodule : apbuart

`default_nettype wire

// File: tb/tb_apbuart.sv
// ============================================================================
//  Module   : tb_apbuart
//  Purpose  : Self-checking bench for apbuart in serial loopback. Expected
//             values come from a queue/level model of the UART registers.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apbuart;

`ifdef APBUART_FIFO_THRESH_EN
    localparam bit THR = 1'b1;
`else
    localparam bit THR = 1'b0;
`endif

    logic PCLK, PRESET, RsRx, RsTx, uart_irq;
    logic loop_en, tb_rx;

    apbuart_if apb_if ();

    apbuart #(.FIFO_AW(4)) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .apb      (apb_if),
        .RsRx     (RsRx),
        .RsTx     (RsTx),
        .uart_irq (uart_irq)
    );

    assign RsRx = loop_en ? RsTx : tb_rx;

    always #5 PCLK = ~PCLK;

    int          errors, checks;
    int          m_im, m_txtr, m_rxtr;
    int          len, pr, wait_cnt;
    logic [31:0] rd, v;
    logic [7:0]  sh, b;
    logic [7:0]  exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    // Model of STATUS from FIFO occupancy and threshold settings
    function automatic logic [31:0] exp_status(input int txl, input int rxl);
        logic lt, gt;
        lt = THR && (txl < m_txtr);
        gt = THR && (rxl > m_rxtr);
        return {26'b0, gt, lt, (rxl == 0), (rxl == 16), (txl == 0), (txl == 16)};
    endfunction

    function automatic logic [31:0] exp_irq(input int txl, input int rxl);
        logic lt, gt, any;
        lt  = THR && (txl < m_txtr);
        gt  = THR && (rxl > m_rxtr);
        any = ((txl != 16) && m_im[1]) || ((rxl != 0) && m_im[2]) ||
              (lt && m_im[3]) || (gt && m_im[4]);
        return {31'b0, m_im[0] & any};
    endfunction

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge PCLK);
        apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b1;
        apb_if.PADDR = {24'b0, a}; apb_if.PWDATA = d;
        @(negedge PCLK);
        apb_if.PENABLE = 1'b1;
        @(negedge PCLK);
        apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge PCLK);
        apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0;
        apb_if.PADDR = {24'b0, a};
        @(negedge PCLK);
        apb_if.PENABLE = 1'b1;
        #1;
        d = apb_if.PRDATA;
        check("pready", {31'b0, apb_if.PREADY}, 32'd1);
        @(negedge PCLK);
        apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0;
        m_im = 0; m_txtr = 0; m_rxtr = 0;
        PCLK = 1'b0; PRESET = 1'b1; loop_en = 1'b1; tb_rx = 1'b1;
        apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0;
        apb_if.PADDR = '0; apb_if.PWDATA = '0;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);

        // ---- reset state and register map
        check("rst_rstx", {31'b0, RsTx}, 32'd1);
        check("rst_irq", {31'b0, uart_irq}, 32'd0);
        apb_read(8'h08, rd); check("rst_presc", rd, 32'd0);
        apb_read(8'h0C, rd); check("rst_im", rd, 32'd0);
        apb_read(8'h10, rd); check("rst_txtr", rd, 32'd0);
        apb_read(8'h14, rd); check("rst_rxtr", rd, 32'd0);
        apb_read(8'h04, rd); check("rst_status", rd, exp_status(0, 0));
        apb_read(8'h18, rd); check("unmapped_18", rd, 32'hDEADDEAD);
        b = 8'h18 + 8'(4 * $urandom_range(0, 57));
        apb_read(b, rd); check("unmapped_rand", rd, 32'hDEADDEAD);

        for (int i = 0; i < 3; i++) begin
            v = $urandom;
            apb_write(8'h08, v); apb_read(8'h08, rd); check("rw_presc", rd, {16'b0, v[15:0]});
            apb_write(8'h0C, v); apb_read(8'h0C, rd); check("rw_im", rd, {27'b0, v[4:0]});
            apb_write(8'h10, v); apb_read(8'h10, rd); check("rw_txtr", rd, THR ? {24'b0, v[7:0]} : 32'd0);
            apb_write(8'h14, v); apb_read(8'h14, rd); check("rw_rxtr", rd, THR ? {24'b0, v[7:0]} : 32'd0);
        end
        apb_write(8'h0C, 0); apb_write(8'h10, 0); apb_write(8'h14, 0);

        // ---- single frame 0x7F at PR=1 (32 clk per bit)
        apb_write(8'h08, 1); apb_write(8'h04, 1); apb_write(8'h00, 32'h7F);
        wait_cnt = 0;
        while (RsTx !== 1'b0 && wait_cnt < 100) begin @(negedge PCLK); wait_cnt++; end
        check("tx_start_seen", {31'b0, RsTx}, 32'd0);
        len = 0;
        while (RsTx === 1'b0 && len < 100) begin len++; @(negedge PCLK); end
        // Start-bit entry is not tick aligned, so it can be one clock short.
        check("tx_start_len", {31'b0, (len == 31 || len == 32)}, 32'd1);
        sh = '0;
        for (int k = 0; k < 8; k++) begin
            repeat (16) @(negedge PCLK);
            sh[k] = RsTx;
            repeat (16) @(negedge PCLK);
        end
        check("tx_bits", {24'b0, sh}, 32'h7F);
        repeat (16) @(negedge PCLK);
        check("tx_stop", {31'b0, RsTx}, 32'd1);
        repeat (40) @(negedge PCLK);
        apb_read(8'h04, rd); check("frame_status", rd, exp_status(0, 1));
        apb_read(8'h00, rd); check("frame_data", rd, 32'h7F);
        apb_read(8'h04, rd); check("frame_status2", rd, exp_status(0, 0));

        // ---- fill TX with EN=0 (17th dropped), then loop 16 random bytes
        apb_write(8'h04, 0);
        pr = $urandom_range(0, 2);
        apb_write(8'h08, pr);
        exp_q.delete();
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            apb_write(8'h00, {24'b0, b});
            if (exp_q.size() < 16) exp_q.push_back(b);
        end
        apb_read(8'h04, rd); check("full_status", rd, exp_status(16, 0));
        apb_write(8'h04, 1);
        repeat (16 * 160 * (pr + 1) + 400) @(negedge PCLK);
        apb_read(8'h04, rd); check("loop16_status", rd, exp_status(0, 16));
        for (int i = 0; i < 16; i++) begin
            apb_read(8'h00, rd); check("loop_data", rd, {24'b0, exp_q[i]});
        end
        apb_read(8'h04, rd); check("drained_status", rd, exp_status(0, 0));

        // ---- interrupt sources IM[1]/IM[2]
        apb_write(8'h08, 1);
        m_im = 5; apb_write(8'h0C, 5);
        @(negedge PCLK); check("irq_rx_empty", {31'b0, uart_irq}, exp_irq(0, 0));
        b = 8'($urandom);
        apb_write(8'h00, {24'b0, b});
        repeat (400) @(negedge PCLK);
        check("irq_rx_byte", {31'b0, uart_irq}, exp_irq(0, 1));
        apb_read(8'h00, rd); check("irq_byte_data", rd, {24'b0, b});
        check("irq_after_pop", {31'b0, uart_irq}, exp_irq(0, 0));
        m_im = 3; apb_write(8'h0C, 3);
        @(negedge PCLK); check("irq_tx_notfull", {31'b0, uart_irq}, exp_irq(0, 0));

        // ---- threshold interrupts
        m_txtr = 6; apb_write(8'h10, 6);
        m_im = 9; apb_write(8'h0C, 9);
        apb_write(8'h04, 0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom); exp_q.push_back(b); apb_write(8'h00, {24'b0, b});
        end
        @(negedge PCLK); check("irq_tx_lt_thr", {31'b0, uart_irq}, exp_irq(3, 0));
        apb_read(8'h04, rd); check("thr_status", rd, exp_status(3, 0));
        m_rxtr = 1; apb_write(8'h14, 1);
        m_im = 17; apb_write(8'h0C, 17);
        apb_write(8'h04, 1);
        repeat (3 * 320 + 400) @(negedge PCLK);
        check("irq_rx_gt_3", {31'b0, uart_irq}, exp_irq(0, 3));
        apb_read(8'h00, rd); check("thr_data0", rd, {24'b0, exp_q[0]});
        check("irq_rx_gt_2", {31'b0, uart_irq}, exp_irq(0, 2));
        apb_read(8'h00, rd); check("thr_data1", rd, {24'b0, exp_q[1]});
        check("irq_rx_gt_1", {31'b0, uart_irq}, exp_irq(0, 1));
        apb_read(8'h00, rd); check("thr_data2", rd, {24'b0, exp_q[2]});

        // ---- reset mid-frame (0x00 keeps the line low through data bits)
        apb_write(8'h00, 32'h00);
        repeat (100) @(negedge PCLK);
        check("midframe_low", {31'b0, RsTx}, 32'd0);
        PRESET = 1'b1;
        #1;
        check("rst_midframe_rstx", {31'b0, RsTx}, 32'd1);
        @(negedge PCLK);
        check("rst_midframe_rstx2", {31'b0, RsTx}, 32'd1);
        PRESET = 1'b0;
        m_im = 0; m_txtr = 0; m_rxtr = 0;
        apb_read(8'h04, rd); check("rst_mid_status", rd, exp_status(0, 0));
        apb_read(8'h08, rd); check("rst_mid_presc", rd, 32'd0);
        check("rst_mid_irq", {31'b0, uart_irq}, 32'd0);

        // ---- 3-tick glitch on RsRx must not produce a byte
        apb_write(8'h08, 1); apb_write(8'h04, 1);
        loop_en = 1'b0;
        @(negedge PCLK); tb_rx = 1'b0;
        repeat (6) @(negedge PCLK); tb_rx = 1'b1;
        repeat (400) @(negedge PCLK);
        apb_read(8'h04, rd); check("glitch_status", rd, exp_status(0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_apbuart

`default_nettype wire
